mips32_regfile: RTL
===================

Name: mips32_regfile

Overview:
- 32 x 32-bit general-purpose register file; sits directly upstream of the 32-bit ALU.
- Read port 1 drives ALU operand a; read port 2 drives ALU operand b.
- The write port takes the writeback result, normally the ALU output o. It also takes the ALU overflow flag ow, so signed add/sub overflow can suppress the write and latch a sticky error.
- Same-cycle write-to-read bypass means a dependent ALU op sees the new value without an extra cycle.

Parameters:
- DATA_W, 32, register and port data width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; must equal 2**ADDR_W.
- BYPASS, 1, 1 = write data forwarded to reads of the same address in the same cycle; 0 = reads return stored value only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr1  in  ADDR_W  read port 1 address (feeds ALU a)
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_addr2  in  ADDR_W  read port 2 address (feeds ALU b)
- rd_data2  out  DATA_W  read port 2 data, combinational
- wr_en  in  1  write request this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data (ALU result o)
- wr_ovf  in  1  ALU overflow flag (ow) for the result being written
- ovf_trap_en  in  1  1 = current op is signed add/sub; overflow blocks the write
- ovf_clr  in  1  synchronous clear of ovf_err
- ovf_err  out  1  sticky overflow-trap flag, registered
- ovf_addr  out  ADDR_W  destination of the first trapped write, registered

Behaviour:
- Clock and reset: one clock domain, clk; rst_n is asynchronous, active-low.
- Reset: while rst_n=0, all 32 registers are 0, ovf_err=0 and ovf_addr=0. Release is synchronous to the next rising clk.
- Reset mid-operation: asserting rst_n during a cycle with wr_en=1 discards the write immediately; no partial state survives.
- Register 0: reads always return 0. Writes to address 0 are ignored (no storage change) but are still evaluated for the trap rule below.
- Write qualifier: eff_wr = wr_en & ~(ovf_trap_en & wr_ovf).
- Write timing: on a rising clk with eff_wr=1 and wr_addr!=0, reg[wr_addr] <= wr_data. The new value is visible from storage the following cycle.
- Reads: rd_dataN = 0 if rd_addrN==0.
  - Otherwise, if BYPASS=1 and eff_wr=1 and wr_addr==rd_addrN, rd_dataN = wr_data.
  - Otherwise rd_dataN = reg[rd_addrN].
  - Purely combinational: zero-cycle latency from address to data.
- Both read ports may address the same register; both return identical data, including the bypass case.
- Trap: on a rising clk with wr_en & ovf_trap_en & wr_ovf:
  - if ovf_err==0: ovf_err <= 1 and ovf_addr <= wr_addr;
  - if ovf_err==1: ovf_addr holds the first trapped address; later traps do not overwrite it.
- wr_ovf is ignored when ovf_trap_en=0, i.e. unsigned/logical ops write normally even if ow=1.
- ovf_clr:
  - ovf_clr=1 on a rising clk clears ovf_err to 0; ovf_addr holds its value.
  - Simultaneous ovf_clr and a new trap: the trap wins, so ovf_err=1 and ovf_addr=new wr_addr.
- No state machine beyond the sticky flag; no X may propagate from unwritten registers, since all are reset.

Decomposition:
- Shared package mips32_pkg:
  - DATA_W, ADDR_W, NREGS, REG_ZERO=5'd0;
  - ALU select constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_XOR=3'b011, ALU_SUB=3'b110.
- Upstream decode sets ovf_trap_en=1 exactly when the select is ALU_ADD or ALU_SUB and the instruction is signed.
- One sub-module, mips32_regfile_rdport: the zero/bypass/storage read mux, instantiated twice.

Test Plan:
- Reset then read: pulse rst_n low mid-cycle, read addrs 0..31 -> all rd_data = 0, ovf_err=0, ovf_addr=0.
- Write then read: write 32'd5 to r3 and 32'd4 to r7, then read r3/r7 -> rd_data1=5, rd_data2=4. Write 32'hFFFFFFFF to r0 -> reads of r0 stay 0.
- Bypass: r9=10, then in one cycle wr_en=1, wr_addr=9, wr_data=22 with rd_addr1=rd_addr2=9 -> both reads 22 before the edge and 22 after it. With BYPASS=0 -> 10 before the edge, 22 after.
- Overflow trap:
  - write 32'd2147483647 to r4, then attempt 32'hFFFFFFFE to r4 with wr_ovf=1, ovf_trap_en=1 -> r4 stays 2147483647, ovf_err=1, ovf_addr=4;
  - repeat to r6 -> ovf_addr stays 4;
  - same stimulus with ovf_trap_en=0 -> r4=32'hFFFFFFFE, no error.
- Clear vs trap: ovf_err=1, then ovf_clr=1 alone -> ovf_err=0, ovf_addr unchanged. Then ovf_clr=1 together with a trapped write to r8 -> ovf_err=1, ovf_addr=8.
- Reset mid-write: wr_en=1, wr_addr=2, wr_data=32'd51 with rst_n falling before the clock edge -> r2=0 after release, ovf_err=0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 datapath constants: widths, the zero register and ALU select codes.
package mips32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Decode raises ovf_trap_en only for signed ALU_ADD / ALU_SUB.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

endpackage

// File: rtl/mips32_regfile_if.sv
// Register-file bus: two combinational read ports, one write port with overflow trap.
interface mips32_regfile_if
    import mips32_pkg::*;
#(
    parameter int unsigned DW = DATA_W,
    parameter int unsigned AW = ADDR_W
) ();

    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ovf;
    logic          ovf_trap_en;
    logic          ovf_clr;
    logic          ovf_err;
    logic [AW-1:0] ovf_addr;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_ovf, ovf_trap_en, ovf_clr,
        input  rd_data1, rd_data2, ovf_err, ovf_addr
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_ovf, ovf_trap_en, ovf_clr,
        output rd_data1, rd_data2, ovf_err, ovf_addr
    );

endinterface

// File: rtl/mips32_regfile_rdport.sv
// One read port: zero register, optional same-cycle write bypass, else stored value.
module mips32_regfile_rdport
    import mips32_pkg::*;
#(
    parameter int unsigned DATA_W = mips32_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips32_pkg::ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              eff_wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = stored;
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end else if (BYPASS && eff_wr && (wr_addr == addr)) begin
            data = wr_data;
        end
    end

endmodule

// File: rtl/mips32_regfile.sv
// 32x32 register file feeding the ALU, with overflow-suppressed writes and a sticky trap flag.
module mips32_regfile
    import mips32_pkg::*;
#(
    parameter int unsigned DATA_W = mips32_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips32_pkg::ADDR_W,
    parameter int unsigned NREGS  = mips32_pkg::NREGS,
    parameter bit          BYPASS = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mips32_regfile_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              eff_wr;
    logic              trap;
    logic              ovf_err_q, ovf_err_d;
    logic [ADDR_W-1:0] ovf_addr_q, ovf_addr_d;

    assign trap   = bus.wr_en & bus.ovf_trap_en & bus.wr_ovf;
    assign eff_wr = bus.wr_en & ~(bus.ovf_trap_en & bus.wr_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (eff_wr && (bus.wr_addr != ADDR_W'(REG_ZERO))) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // A trap outranks a simultaneous clear, and a clear re-arms capture of the address.
    always_comb begin
        ovf_err_d  = ovf_err_q;
        ovf_addr_d = ovf_addr_q;
        if (trap) begin
            ovf_err_d = 1'b1;
            if (!ovf_err_q || bus.ovf_clr) begin
                ovf_addr_d = bus.wr_addr;
            end
        end else if (bus.ovf_clr) begin
            ovf_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_q  <= 1'b0;
            ovf_addr_q <= '0;
        end else begin
            ovf_err_q  <= ovf_err_d;
            ovf_addr_q <= ovf_addr_d;
        end
    end

    assign bus.ovf_err  = ovf_err_q;
    assign bus.ovf_addr = ovf_addr_q;

    mips32_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rdport1 (
        .addr    (bus.rd_addr1),
        .stored  (regs_q[bus.rd_addr1]),
        .eff_wr  (eff_wr),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .data    (bus.rd_data1)
    );

    mips32_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rdport2 (
        .addr    (bus.rd_addr2),
        .stored  (regs_q[bus.rd_addr2]),
        .eff_wr  (eff_wr),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .data    (bus.rd_data2)
    );

endmodule
